cordic_prerotate_stage: RTL and testbench

//  Registered, parametrised CORDIC front end. Folds an input angle or vector into

---
 rtl/cordic_prerotate_stage.sv | 140 ++++++++++++++
 tb/tb_cordic_prerotate_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_prerotate_stage.sv
// CORDIC pre-rotation stage: folds angle/vector into quadrant 0, registered with valid/ready.
// Define CORDIC_PRE_SAT_EN for saturating negation and a live sat_flag.
module cordic_prerotate_stage #(
  parameter int DATA_W  = 16,
  parameter int ANGLE_W = 16,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [DATA_W-1:0]  x_in,
  input  logic [DATA_W-1:0]  y_in,
  input  logic [ANGLE_W-1:0] theta_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [TAG_W-1:0]   out_tag,
  output logic [DATA_W-1:0]  x_out,
  output logic [DATA_W-1:0]  y_out,
  output logic [ANGLE_W-1:0] theta_out,
  output logic [1:0]         quadrant,
  output logic               sat_flag
);

  localparam logic [DATA_W-1:0] S_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ANGLE_W-1:0] A_MASK =
    {1'b0, {(ANGLE_W-1){1'b1}}};
  localparam logic [ANGLE_W-1:0] Q_MASK =
    {3'b000, {(ANGLE_W-3){1'b1}}};

`ifdef CORDIC_PRE_SAT_EN
  localparam logic [DATA_W-1:0] S_MAX = ~S_MIN;

  function automatic logic [DATA_W-1:0] neg(
    input logic [DATA_W-1:0] v
  );
    if (v == S_MIN) return S_MAX;
    return -v;
  endfunction
`else
  function automatic logic [DATA_W-1:0] neg(
    input logic [DATA_W-1:0] v
  );
    return -v;
  endfunction
`endif

  logic [ANGLE_W-1:0] w_a;
  logic [ANGLE_W-1:0] w_theta;
  logic [1:0]         w_q;
  logic [DATA_W-1:0]  w_nx;
  logic [DATA_W-1:0]  w_ny;
  logic [DATA_W-1:0]  w_x;
  logic [DATA_W-1:0]  w_y;
  logic               w_acc;

  assign in_ready = !out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;

  // Bit ANGLE_W-1 is one full turn, so masking it wraps the angle.
  assign w_a  = theta_in & A_MASK;
  assign w_nx = neg(x_in);
  assign w_ny = neg(y_in);

  always_comb begin
    w_q     = 2'd0;
    w_theta = w_a;
    if (in_mode) begin
      w_q     = {y_in[DATA_W-1], x_in[DATA_W-1] ^ y_in[DATA_W-1]};
      w_theta = w_a;
    end else begin
      w_q     = w_a[ANGLE_W-2:ANGLE_W-3];
      w_theta = w_a & Q_MASK;
    end
  end

  always_comb begin
    w_x = x_in;
    w_y = y_in;
    unique case (w_q)
      2'd0: begin w_x = x_in; w_y = y_in; end
      2'd1: begin w_x = y_in; w_y = w_nx; end
      2'd2: begin w_x = w_nx; w_y = w_ny; end
      2'd3: begin w_x = w_ny; w_y = x_in; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
      x_out     <= '0;
      y_out     <= '0;
      theta_out <= '0;
      quadrant  <= 2'd0;
    end else if (w_acc) begin
      out_valid <= 1'b1;
      out_mode  <= in_mode;
      out_tag   <= in_tag;
      x_out     <= w_x;
      y_out     <= w_y;
      theta_out <= w_theta;
      quadrant  <= w_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CORDIC_PRE_SAT_EN
  logic w_xmin;
  logic w_ymin;
  logic w_sat;

  assign w_xmin = (x_in == S_MIN);
  assign w_ymin = (y_in == S_MIN);

  always_comb begin
    w_sat = 1'b0;
    unique case (w_q)
      2'd0: w_sat = 1'b0;
      2'd1: w_sat = w_xmin;
      2'd2: w_sat = w_xmin || w_ymin;
      2'd3: w_sat = w_ymin;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) sat_flag <= 1'b0;
    else if (w_acc) sat_flag <= w_sat;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_prerotate_stage.sv
// Directed bench for cordic_prerotate_stage (16-bit data/angle).
// Expected values are hand-computed from the quadrant fold rules.
module tb_cordic_prerotate_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [3:0]  in_tag;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [15:0] theta_in;
  logic        out_valid;
  logic        out_ready;
  logic        out_mode;
  logic [3:0]  out_tag;
  logic [15:0] x_out;
  logic [15:0] y_out;
  logic [15:0] theta_out;
  logic [1:0]  quadrant;
  logic        sat_flag;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_prerotate_stage #(
    .DATA_W(16), .ANGLE_W(16), .TAG_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_tag(in_tag),
    .x_in(x_in), .y_in(y_in), .theta_in(theta_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_tag(out_tag),
    .x_out(x_out), .y_out(y_out),
    .theta_out(theta_out), .quadrant(quadrant),
    .sat_flag(sat_flag)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic m, input logic [3:0] t,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] th);
    in_valid = 1'b1;
    in_mode  = m;
    in_tag   = t;
    x_in     = x;
    y_in     = y;
    theta_in = th;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_tag = '0;
    x_in = '0; y_in = '0; theta_in = '0; out_ready = 1'b1;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_th", theta_out, 0);
    chk("rst_q", quadrant, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_mode", out_mode, 0);
    chk("rst_sat", sat_flag, 0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", in_ready, 1);

    drive(1'b0, 4'd1, 16'h1000, 16'h0200, 16'h2345);
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_q", quadrant, 1);
    chk("t1_th", theta_out, 16'h0345);
    chk("t1_x", x_out, 16'h0200);
    chk("t1_y", y_out, 16'hF000);
    chk("t1_tag", out_tag, 1);

    drive(1'b0, 4'd2, 16'h1234, 16'h0000, 16'h8000);
    step();
    chk("t2a_q", quadrant, 0);
    chk("t2a_th", theta_out, 0);
    chk("t2a_x", x_out, 16'h1234);

    drive(1'b0, 4'd3, 16'h0100, 16'h0200, 16'h7FFF);
    step();
    chk("t2b_q", quadrant, 3);
    chk("t2b_th", theta_out, 16'h1FFF);
    chk("t2b_x", x_out, 16'hFE00);
    chk("t2b_y", y_out, 16'h0100);

    drive(1'b1, 4'd4, 16'hF000, 16'hF800, 16'hC123);
    step();
    chk("t3_q", quadrant, 2);
    chk("t3_x", x_out, 16'h1000);
    chk("t3_y", y_out, 16'h0800);
    chk("t3_th", theta_out, 16'h4123);
    chk("t3_mode", out_mode, 1);

    drive(1'b1, 4'd5, 16'hFFFF, 16'h0005, 16'h0000);
    step();
    chk("vq1_q", quadrant, 1);
    chk("vq1_x", x_out, 16'h0005);
    chk("vq1_y", y_out, 16'h0001);

    drive(1'b1, 4'd6, 16'h0003, 16'hFFFE, 16'h0000);
    step();
    chk("vq3_q", quadrant, 3);
    chk("vq3_x", x_out, 16'h0002);
    chk("vq3_y", y_out, 16'h0003);

    drive(1'b0, 4'd7, 16'h8000, 16'h0010, 16'h4000);
    step();
    chk("t4_q", quadrant, 2);
    chk("t4_y", y_out, 16'hFFF0);
`ifdef CORDIC_PRE_SAT_EN
    chk("t4_x", x_out, 16'h7FFF);
    chk("t4_sat", sat_flag, 1);
`else
    chk("t4_x", x_out, 16'h8000);
    chk("t4_sat", sat_flag, 0);
`endif

    in_valid = 1'b0;
    step();
    chk("idle_valid", out_valid, 0);
    chk("idle_hold_y", y_out, 16'hFFF0);

    out_ready = 1'b0;
    drive(1'b0, 4'd5, 16'h0100, 16'h0000, 16'h0010);
    step();
    chk("t5_first_valid", out_valid, 1);
    drive(1'b0, 4'd6, 16'h0200, 16'h0000, 16'h2000);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_stall_rdy", in_ready, 0);
      step();
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_tag", out_tag, 5);
      chk("t5_hold_x", x_out, 16'h0100);
      chk("t5_hold_th", theta_out, 16'h0010);
    end
    out_ready = 1'b1;
    #1;
    chk("t5_release_rdy", in_ready, 1);
    step();
    chk("t5_second_valid", out_valid, 1);
    chk("t5_second_tag", out_tag, 6);
    chk("t5_second_q", quadrant, 1);
    chk("t5_second_x", x_out, 16'h0000);
    chk("t5_second_y", y_out, 16'hFE00);
    in_valid = 1'b0;
    step();
    chk("t5_drain", out_valid, 0);

    drive(1'b1, 4'd7, 16'h0300, 16'h0100, 16'h1111);
    step();
    chk("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    chk("t6_valid", out_valid, 0);
    chk("t6_x", x_out, 0);
    chk("t6_th", theta_out, 0);
    chk("t6_tag", out_tag, 0);
    chk("t6_mode", out_mode, 0);
    rst = 1'b0;
    #1;
    chk("t6_rdy", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'(8 + k), 16'(16 * (k + 1)), 16'h0000, 16'h0001);
      step();
      chk("t6_stream_valid", out_valid, 1);
      chk("t6_stream_tag", out_tag, 8 + k);
      chk("t6_stream_x", x_out, 16 * (k + 1));
    end
    in_valid = 1'b0;
    step();
    chk("t6_end", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
